// File: rtl/ripple_chk_pkg.sv
// Shared types and constants for the ripple counter checker.
// Counter width, wrap value and checker state encoding.
package ripple_chk_pkg;

  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = 4'hF;

  typedef enum logic [1:0] {
    IDLE,
    SYNC,
    TRACK,
    ERROR
  } state_t;

  function automatic logic [CNT_W-1:0] cnt_inc(
    input logic [CNT_W-1:0] v
  );
    return v + 1'b1;
  endfunction

endpackage

// File: rtl/sync_filter.sv
// Two-flop synchroniser followed by a run-length stability filter.
// A value counts as stable once seen STABLE consecutive cycles.
module sync_filter #(
  parameter int WIDTH  = 4,
  parameter int STABLE = 2
) (
  input  logic             clock,
  input  logic             clear_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] value,
  output logic             stable,
  output logic             accept
);

  localparam int RW = $clog2(STABLE + 1) + 1;
  localparam logic [RW-1:0] STB = RW'(STABLE);

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;
  logic [WIDTH-1:0] hist;
  logic [RW-1:0]    run_q;
  logic [RW-1:0]    len;
  logic             same;

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      s1    <= '0;
      s2    <= '0;
      hist  <= '0;
      run_q <= '0;
    end else begin
      s1    <= d;
      s2    <= s1;
      hist  <= s2;
      run_q <= len;
    end
  end

  // len: how many consecutive cycles s2 has held its present value
  always_comb begin
    same = (s2 == hist);
    len  = RW'(1);
    if (same) begin
      len = (run_q >= STB) ? STB : run_q + RW'(1);
    end
  end

  assign value  = s2;
  assign stable = (len >= STB);
  assign accept = (len == STB) && !(same && run_q == STB);

endmodule

// File: rtl/ripple_count_checker.sv
// Checks a resynchronised ripple counter advances by +1 mod 16
// and counts its completed wraps.
module ripple_count_checker
  import ripple_chk_pkg::*;
#(
  parameter int STABLE = 2,
  parameter int WRAP_W = 8
) (
  input  logic              clock,
  input  logic              clear_n,
  input  logic [CNT_W-1:0]  q_in,
  input  logic              cnt_clear,
  output logic [CNT_W-1:0]  count,
  output logic              count_valid,
  output logic              wrap_pulse,
  output logic [WRAP_W-1:0] wrap_count,
  output logic              seq_err
);

  logic [CNT_W-1:0] q_val;
  logic             q_stb;
  logic             q_acc;
  logic [0:0]       c_val;
  logic             c_stb;
  logic             c_acc_unused;
  logic             clr;
  logic             take;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WRAP_W-1:0] wc_q, wc_d;
  logic             wp_q, wp_d;
  logic             err_q, err_d;

  sync_filter #(
    .WIDTH  (CNT_W),
    .STABLE (STABLE)
  ) u_q_filt (
    .clock   (clock),
    .clear_n (clear_n),
    .d       (q_in),
    .value   (q_val),
    .stable  (q_stb),
    .accept  (q_acc)
  );

  sync_filter #(
    .WIDTH  (1),
    .STABLE (1)
  ) u_c_filt (
    .clock   (clock),
    .clear_n (clear_n),
    .d       (cnt_clear),
    .value   (c_val),
    .stable  (c_stb),
    .accept  (c_acc_unused)
  );

  assign clr  = c_val[0] & c_stb;
  assign take = q_acc && (q_val != count_q);

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state_q <= IDLE;
      count_q <= '0;
      wc_q    <= '0;
      wp_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      wc_q    <= wc_d;
      wp_q    <= wp_d;
      err_q   <= err_d;
    end
  end

  // clear wins over any same-cycle acceptance
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    wc_d    = wc_q;
    wp_d    = 1'b0;
    err_d   = err_q;
    if (clr) begin
      state_d = IDLE;
      count_d = '0;
      err_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          count_d = '0;
          err_d   = 1'b0;
          state_d = SYNC;
        end
        SYNC: begin
          if (q_stb) begin
            if (q_val == '0) begin
              state_d = TRACK;
            end else begin
              err_d   = 1'b1;
              count_d = q_val;
              state_d = ERROR;
            end
          end
        end
        TRACK: begin
          if (take) begin
            count_d = q_val;
            if (q_val == cnt_inc(count_q)) begin
              if (count_q == CNT_MAX) begin
                wp_d = 1'b1;
                if (wc_q != '1) begin
                  wc_d = wc_q + 1'b1;
                end
              end
            end else begin
              err_d   = 1'b1;
              state_d = ERROR;
            end
          end
        end
        ERROR: begin
          if (take) begin
            count_d = q_val;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign count       = count_q;
  assign count_valid = (state_q == TRACK) || (state_q == ERROR);
  assign wrap_pulse  = wp_q;
  assign wrap_count  = wc_q;
  assign seq_err     = err_q;

endmodule

// File: tb/tb_ripple_count_checker.sv
// Randomised bench for ripple_count_checker against a behavioural model.
module tb_ripple_count_checker;

  logic       clock;
  logic       clear_n;
  logic [3:0] q_in;
  logic       cnt_clear;

  logic [3:0] count1, count2;
  logic       valid1, valid2;
  logic       wp1, wp2;
  logic [7:0] wc1;
  logic [1:0] wc2;
  logic       err1, err2;

  ripple_count_checker dut (
    .clock       (clock),
    .clear_n     (clear_n),
    .q_in        (q_in),
    .cnt_clear   (cnt_clear),
    .count       (count1),
    .count_valid (valid1),
    .wrap_pulse  (wp1),
    .wrap_count  (wc1),
    .seq_err     (err1)
  );

  ripple_count_checker #(.STABLE(2), .WRAP_W(2)) dut2 (
    .clock       (clock),
    .clear_n     (clear_n),
    .q_in        (q_in),
    .cnt_clear   (cnt_clear),
    .count       (count2),
    .count_valid (valid2),
    .wrap_pulse  (wp2),
    .wrap_count  (wc2),
    .seq_err     (err2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  localparam int STB = 2;
  localparam int M_IDLE = 0;
  localparam int M_SYNC = 1;
  localparam int M_TRACK = 2;
  localparam int M_ERR = 3;

  int checks = 0;
  int passes = 0;
  int pulses1 = 0;
  int pulses2 = 0;
  bit chk_en = 0;

  // model: queue of synchronised samples, newest last
  int mq[$];
  int m_s1;
  int m_c1, m_c2;
  int mode;
  int m_cnt, m_wc, m_wp, m_err;
  int r, v;
  bit stb, acc;

  function automatic void model_reset();
    mq.delete();
    mq.push_back(0);
    m_s1 = 0; m_c1 = 0; m_c2 = 0;
    mode = M_IDLE;
    m_cnt = 0; m_wc = 0; m_wp = 0; m_err = 0;
  endfunction

  function automatic int run_len();
    int n = 1;
    for (int i = mq.size() - 2; i >= 0; i--) begin
      if (mq[i] != mq[mq.size()-1] || n > STB) break;
      n++;
    end
    return n;
  endfunction

  always @(posedge clock) begin
    if (!clear_n) begin
      model_reset();
    end else begin
      r = run_len();
      stb = (r >= STB);
      acc = (r == STB);
      v = mq[mq.size()-1];
      m_wp = 0;
      if (m_c2 != 0) begin
        mode = M_IDLE; m_cnt = 0; m_err = 0;
      end else if (mode == M_IDLE) begin
        mode = M_SYNC;
      end else if (mode == M_SYNC) begin
        if (stb) begin
          if (v == 0) mode = M_TRACK;
          else begin m_err = 1; m_cnt = v; mode = M_ERR; end
        end
      end else if (mode == M_TRACK) begin
        if (acc && v != m_cnt) begin
          if (v == (m_cnt + 1) % 16) begin
            if (m_cnt == 15) begin m_wp = 1; m_wc++; end
            m_cnt = v;
          end else begin
            m_err = 1; m_cnt = v; mode = M_ERR;
          end
        end
      end else begin
        if (acc && v != m_cnt) m_cnt = v;
      end
      mq.push_back(m_s1);
      if (mq.size() > 8) void'(mq.pop_front());
      m_s1 = int'(q_in);
      m_c2 = m_c1;
      m_c1 = int'(cnt_clear);
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      int e_val, e_wc1, e_wc2;
      e_val = (mode == M_TRACK || mode == M_ERR) ? 1 : 0;
      e_wc1 = (m_wc > 255) ? 255 : m_wc;
      e_wc2 = (m_wc > 3) ? 3 : m_wc;
      checks++;
      if (int'(count1) == m_cnt && int'(valid1) == e_val &&
          int'(wp1) == m_wp && int'(wc1) == e_wc1 &&
          int'(err1) == m_err && int'(wp2) == m_wp &&
          int'(wc2) == e_wc2 && int'(count2) == m_cnt)
        passes++;
      else
        $display("FAIL cycle t=%0t cnt %0d/%0d val %0d/%0d wp %0d/%0d wc %0d/%0d wc2 %0d/%0d err %0d/%0d (got/exp)",
                 $time, count1, m_cnt, valid1, e_val, wp1, m_wp,
                 wc1, e_wc1, wc2, e_wc2, err1, m_err);
      if (wp1) pulses1++;
      if (wp2) pulses2++;
    end
  end

  task automatic check(input string nm, input int got, input int exp);
    checks++;
    if (got == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", nm, got, exp);
  endtask

  task automatic hold(input logic [3:0] val, input int n);
    q_in = val;
    repeat (n) @(negedge clock);
  endtask

  // emulate the ripple chain's transient codes, one cycle each
  task automatic ripple_to(input int n);
    logic [3:0] a, cur;
    a = q_in;
    cur = a;
    for (int i = 0; i < 4; i++) begin
      cur[i] = ~cur[i];
      if (!a[i] || i == 3) break;
      q_in = cur;
      @(negedge clock);
    end
    q_in = a + 4'd1;
    repeat (n) @(negedge clock);
  endtask

  task automatic clr_pulse(input int n);
    cnt_clear = 1'b1;
    repeat (n) @(negedge clock);
    q_in = 4'h0;
    cnt_clear = 1'b0;
    repeat (8) @(negedge clock);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int p, sel;
    model_reset();
    clear_n = 1'b1;
    q_in = 4'h9;
    cnt_clear = 1'b1;
    #1 clear_n = 1'b0;
    chk_en = 1;
    repeat (3) @(negedge clock);
    check("rst_count", count1, 0);
    check("rst_valid", valid1, 0);
    check("rst_wp", wp1, 0);
    check("rst_wc", wc1, 0);
    check("rst_err", err1, 0);
    clear_n = 1'b1;
    repeat (6) @(negedge clock);
    check("rel_idle_valid", valid1, 0);
    check("rel_idle_count", count1, 0);

    q_in = 4'h0;
    cnt_clear = 1'b0;
    repeat (8) @(negedge clock);
    check("sync_to_track", valid1, 1);
    p = pulses1;
    for (int i = 1; i <= 17; i++) begin
      q_in = 4'(i % 16);
      if (i == 5) begin
        repeat (3) @(negedge clock);
        check("lat_before", count1, 4);
        @(negedge clock);
        check("lat_at3", count1, 5);
        repeat (6) @(negedge clock);
      end else begin
        repeat (10) @(negedge clock);
      end
    end
    check("clean_count", count1, 1);
    check("clean_wc", wc1, 1);
    check("clean_pulses", pulses1 - p, 1);
    check("clean_err", err1, 0);

    for (int i = 0; i < 6; i++) ripple_to(6);
    check("pre_ripple", count1, 7);
    ripple_to(6);
    check("ripple_count", count1, 8);
    check("ripple_err", err1, 0);

    clr_pulse(4);
    for (int i = 1; i <= 3; i++) hold(4'(i), 6);
    hold(4'h5, 8);
    check("skip_err", err1, 1);
    check("skip_count", count1, 5);
    check("skip_valid", valid1, 1);
    cnt_clear = 1'b1;
    repeat (4) @(negedge clock);
    check("skip_clr_err", err1, 0);
    check("skip_clr_valid", valid1, 0);
    q_in = 4'h0;
    cnt_clear = 1'b0;
    repeat (8) @(negedge clock);

    p = pulses2;
    for (int w = 0; w < 5; w++)
      for (int i = 0; i < 16; i++) ripple_to(5);
    check("sat_wc2", wc2, 3);
    check("sat_pulses2", pulses2 - p, 5);
    check("sat_wc1", wc1, 6);

    for (int i = 0; i < 15; i++) ripple_to(5);
    check("race_pre", count1, 15);
    p = pulses1;
    q_in = 4'h0;
    @(negedge clock);
    cnt_clear = 1'b1;
    repeat (6) @(negedge clock);
    check("race_pulses", pulses1 - p, 0);
    check("race_count", count1, 0);
    check("race_valid", valid1, 0);
    check("race_wc", wc1, 6);

    cnt_clear = 1'b0;
    repeat (8) @(negedge clock);
    for (int i = 0; i < 5; i++) ripple_to(5);
    #2 clear_n = 1'b0;
    #1;
    check("async_count", count1, 0);
    check("async_wc", wc1, 0);
    check("async_valid", valid1, 0);
    @(negedge clock);
    @(negedge clock);
    clear_n = 1'b1;
    repeat (8) @(negedge clock);
    check("restart_err", err1, 1);

    clr_pulse(3);
    for (int it = 0; it < 250; it++) begin
      sel = int'($urandom_range(0, 99));
      if (sel < 78) begin
        ripple_to(int'($urandom_range(4, 8)));
      end else if (sel < 86) begin
        hold(4'($urandom_range(0, 15)), 1);
        hold(4'($urandom_range(0, 15)), int'($urandom_range(4, 8)));
      end else if (sel < 96) begin
        cnt_clear = 1'b1;
        if ($urandom_range(0, 1) == 1) q_in = 4'h0;
        repeat (int'($urandom_range(1, 5))) @(negedge clock);
        cnt_clear = 1'b0;
        repeat (int'($urandom_range(4, 8))) @(negedge clock);
      end else begin
        clear_n = 1'b0;
        repeat (int'($urandom_range(1, 3))) @(negedge clock);
        clear_n = 1'b1;
        repeat (4) @(negedge clock);
      end
    end

    chk_en = 0;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
